// File: rtl/rf_arb_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
// Entries carry a destination index and 32-bit write data.
package rf_arb_pkg;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t    dest;
    logic [31:0] data;
  } wb_entry_t;

  localparam int unsigned DefFifoDepth = 2;
  localparam int unsigned DefMaxWait   = 4;

  function automatic logic [31:0] idx_onehot(reg_idx_t idx);
    idx_onehot = 32'd1 << idx;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries with full/empty flags.
// DEPTH must be a power of two and at least 2.
module wb_fifo
  import rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DefFifoDepth
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  wb_entry_t   mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between pipeline writeback and buffered M-unit results,
// and tracks outstanding M-unit destinations to stall decode on RAW/WAW hazards.
module regfile_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DefFifoDepth,
  parameter int unsigned MAX_WAIT   = DefMaxWait
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_wb_valid,
  input  logic [4:0]  pipe_wb_dest,
  input  logic [31:0] pipe_wb_data,
  output logic        pipe_wb_stall,
  input  logic        md_issue,
  input  logic [4:0]  md_issue_dest,
  input  logic        md_rsp_valid,
  input  logic [4:0]  md_rsp_dest,
  input  logic [31:0] md_rsp_data,
  output logic        md_rsp_ready,
  input  logic [4:0]  dec_src_a,
  input  logic [4:0]  dec_src_b,
  input  logic [4:0]  dec_dest,
  output logic        hazard_stall,
  output logic        rf_load,
  output logic [4:0]  rf_dest,
  output logic [31:0] rf_in,
  output logic [31:0] busy_vec
);

  localparam int unsigned   WW      = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WaitMax = WW'(MAX_WAIT);

  wb_entry_t     head, push_entry;
  logic          fifo_full, fifo_empty, fifo_push;
  logic          md_grant;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   busy_q, busy_d, clr_mask, busy_eff;
  logic          wr_any;
  reg_idx_t      wr_dest;
  logic [31:0]   wr_data;

  assign push_entry   = '{dest: md_rsp_dest, data: md_rsp_data};
  assign md_rsp_ready = rst_n && !fifo_full;
  assign fifo_push    = md_rsp_valid && md_rsp_ready;

  wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_data(push_entry),
    .pop      (md_grant),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // M-unit head preempts the pipeline once it has waited MAX_WAIT cycles.
  always_comb begin
    md_grant = rst_n && !fifo_empty && (!pipe_wb_valid || (wait_cnt_q == WaitMax));
  end

  always_comb begin
    wr_any  = 1'b0;
    wr_dest = '0;
    wr_data = '0;
    if (md_grant) begin
      wr_any  = 1'b1;
      wr_dest = head.dest;
      wr_data = head.data;
    end else if (rst_n && pipe_wb_valid) begin
      wr_any  = 1'b1;
      wr_dest = pipe_wb_dest;
      wr_data = pipe_wb_data;
    end
    rf_load       = wr_any && (wr_dest != '0);
    rf_dest       = wr_dest;
    rf_in         = wr_data;
    pipe_wb_stall = pipe_wb_valid && md_grant;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (fifo_empty || md_grant) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WaitMax) begin
      wait_cnt_d = wait_cnt_q + WW'(1);
    end
  end

  // The index written this cycle is already forwarded by the regfile, so it no longer stalls.
  always_comb begin
    clr_mask = md_grant ? idx_onehot(head.dest) : 32'd0;
    busy_eff = busy_q & ~clr_mask;
    busy_d   = busy_eff;
    if (md_issue && (md_issue_dest != '0)) begin
      busy_d[md_issue_dest] = 1'b1;
    end
  end

  always_comb begin
    hazard_stall = rst_n && (((dec_src_a != '0) && busy_eff[dec_src_a]) ||
                             ((dec_src_b != '0) && busy_eff[dec_src_b]) ||
                             ((dec_dest  != '0) && busy_eff[dec_dest]));
    busy_vec     = rst_n ? busy_q : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      busy_q     <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      busy_q     <= busy_d;
    end
  end

  a_issue_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (md_issue && (md_issue_dest != '0)) |-> !busy_eff[md_issue_dest]);

  a_pipe_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (pipe_wb_valid && (pipe_wb_dest != '0)) |-> !busy_q[pipe_wb_dest]);

  // x0 responses are legal and simply discarded on pop.
  a_rsp_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (fifo_push && (md_rsp_dest != '0)) |-> busy_q[md_rsp_dest]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter with default parameters
// (FIFO_DEPTH=2, MAX_WAIT=4).
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_wb_valid, pipe_wb_stall;
  logic [4:0]  pipe_wb_dest;
  logic [31:0] pipe_wb_data;
  logic        md_issue;
  logic [4:0]  md_issue_dest;
  logic        md_rsp_valid, md_rsp_ready;
  logic [4:0]  md_rsp_dest;
  logic [31:0] md_rsp_data;
  logic [4:0]  dec_src_a, dec_src_b, dec_dest;
  logic        hazard_stall, rf_load;
  logic [4:0]  rf_dest;
  logic [31:0] rf_in, busy_vec;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pipe_wb_valid(pipe_wb_valid),
    .pipe_wb_dest (pipe_wb_dest),
    .pipe_wb_data (pipe_wb_data),
    .pipe_wb_stall(pipe_wb_stall),
    .md_issue     (md_issue),
    .md_issue_dest(md_issue_dest),
    .md_rsp_valid (md_rsp_valid),
    .md_rsp_dest  (md_rsp_dest),
    .md_rsp_data  (md_rsp_data),
    .md_rsp_ready (md_rsp_ready),
    .dec_src_a    (dec_src_a),
    .dec_src_b    (dec_src_b),
    .dec_dest     (dec_dest),
    .hazard_stall (hazard_stall),
    .rf_load      (rf_load),
    .rf_dest      (rf_dest),
    .rf_in        (rf_in),
    .busy_vec     (busy_vec)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] d);
    md_issue      = 1'b1;
    md_issue_dest = d;
    tick();
    md_issue      = 1'b0;
    md_issue_dest = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    pipe_wb_valid = 1'b0; pipe_wb_dest = '0; pipe_wb_data = '0;
    md_issue = 1'b0; md_issue_dest = '0;
    md_rsp_valid = 1'b0; md_rsp_dest = '0; md_rsp_data = '0;
    dec_src_a = '0; dec_src_b = '0; dec_dest = '0;

    // Reset: outputs held at zero even with pipeline activity.
    pipe_wb_valid = 1'b1; pipe_wb_dest = 5'd3; pipe_wb_data = 32'h33;
    tick(); tick();
    check("rst_load", {31'd0, rf_load}, 32'd0);
    check("rst_dest", {27'd0, rf_dest}, 32'd0);
    check("rst_ready", {31'd0, md_rsp_ready}, 32'd0);
    check("rst_busy", busy_vec, 32'd0);
    rst_n = 1'b1; pipe_wb_valid = 1'b0;
    #1;
    check("rel_ready", {31'd0, md_rsp_ready}, 32'd1);

    // Idle pipe, M result to x5.
    issue(5'd5);
    check("t1_busy_set", busy_vec, 32'h0000_0020);
    md_rsp_valid = 1'b1; md_rsp_dest = 5'd5; md_rsp_data = 32'hDEAD_BEEF;
    #1;
    check("t1_push_noload", {31'd0, rf_load}, 32'd0);
    tick();
    md_rsp_valid = 1'b0;
    #1;
    check("t1_load", {31'd0, rf_load}, 32'd1);
    check("t1_dest", {27'd0, rf_dest}, 32'd5);
    check("t1_data", rf_in, 32'hDEAD_BEEF);
    check("t1_stall", {31'd0, pipe_wb_stall}, 32'd0);
    tick();
    check("t1_busy_clr", busy_vec, 32'd0);
    check("t1_idle", {31'd0, rf_load}, 32'd0);

    // RAW hazard on x7 drops in the write cycle.
    issue(5'd7);
    dec_src_a = 5'd7;
    #1;
    check("t2_haz0", {31'd0, hazard_stall}, 32'd1);
    tick();
    check("t2_haz1", {31'd0, hazard_stall}, 32'd1);
    md_rsp_valid = 1'b1; md_rsp_dest = 5'd7; md_rsp_data = 32'h0000_0077;
    #1;
    check("t2_haz_push", {31'd0, hazard_stall}, 32'd1);
    tick();
    md_rsp_valid = 1'b0;
    #1;
    check("t2_haz_wr", {31'd0, hazard_stall}, 32'd0);
    check("t2_wr_dest", {27'd0, rf_dest}, 32'd7);
    tick();
    check("t2_haz_after", {31'd0, hazard_stall}, 32'd0);
    dec_src_a = '0;

    // src_b and WAW on dec_dest.
    issue(5'd9);
    dec_src_b = 5'd9;
    #1;
    check("t2_haz_b", {31'd0, hazard_stall}, 32'd1);
    dec_src_b = 5'd0; dec_dest = 5'd9;
    #1;
    check("t2_haz_waw", {31'd0, hazard_stall}, 32'd1);
    dec_dest = 5'd8;
    #1;
    check("t2_haz_none", {31'd0, hazard_stall}, 32'd0);
    dec_dest = '0;
    md_rsp_valid = 1'b1; md_rsp_dest = 5'd9; md_rsp_data = 32'h99;
    tick();
    md_rsp_valid = 1'b0;
    tick();

    // MAX_WAIT preemption with pipeline continuously valid.
    issue(5'd10);
    pipe_wb_valid = 1'b1; pipe_wb_dest = 5'd3; pipe_wb_data = 32'h33;
    md_rsp_valid = 1'b1; md_rsp_dest = 5'd10; md_rsp_data = 32'h0000_A0A0;
    #1;
    check("t3_push_pipe", {27'd0, rf_dest}, 32'd3);
    tick();
    md_rsp_valid = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_pipe%0d_dest", i), {27'd0, rf_dest}, 32'd3);
      check($sformatf("t3_pipe%0d_stall", i), {31'd0, pipe_wb_stall}, 32'd0);
      tick();
    end
    check("t3_m_stall", {31'd0, pipe_wb_stall}, 32'd1);
    check("t3_m_dest", {27'd0, rf_dest}, 32'd10);
    check("t3_m_data", rf_in, 32'h0000_A0A0);
    check("t3_m_load", {31'd0, rf_load}, 32'd1);
    tick();
    check("t3_resume_stall", {31'd0, pipe_wb_stall}, 32'd0);
    check("t3_resume_dest", {27'd0, rf_dest}, 32'd3);
    pipe_wb_valid = 1'b0;
    tick();
    check("t3_busy", busy_vec, 32'd0);

    // Three back-to-back responses into a 2-deep FIFO.
    issue(5'd11); issue(5'd12); issue(5'd13);
    pipe_wb_valid = 1'b1;
    md_rsp_valid = 1'b1; md_rsp_dest = 5'd11; md_rsp_data = 32'h0000_0C11;
    #1;
    check("t4_rdy0", {31'd0, md_rsp_ready}, 32'd1);
    tick();
    md_rsp_dest = 5'd12; md_rsp_data = 32'h0000_0C12;
    #1;
    check("t4_rdy1", {31'd0, md_rsp_ready}, 32'd1);
    tick();
    md_rsp_dest = 5'd13; md_rsp_data = 32'h0000_0C13;
    #1;
    check("t4_full", {31'd0, md_rsp_ready}, 32'd0);
    tick();
    n = 0;
    while (!pipe_wb_stall && n < 10) begin
      tick();
      n++;
    end
    check("t4_wait_cycles", n, 32'd2);
    check("t4_pop_dest", {27'd0, rf_dest}, 32'd11);
    check("t4_no_bypass", {31'd0, md_rsp_ready}, 32'd0);
    tick();
    pipe_wb_valid = 1'b0;
    #1;
    check("t4_rdy_after_pop", {31'd0, md_rsp_ready}, 32'd1);
    check("t4_dest12", {27'd0, rf_dest}, 32'd12);
    check("t4_data12", rf_in, 32'h0000_0C12);
    tick();
    md_rsp_valid = 1'b0;
    #1;
    check("t4_dest13", {27'd0, rf_dest}, 32'd13);
    check("t4_load13", {31'd0, rf_load}, 32'd1);
    tick();
    check("t4_drained", {31'd0, rf_load}, 32'd0);
    check("t4_busy", busy_vec, 32'd0);

    // x0 response while x14 busy: popped without a write or scoreboard change.
    issue(5'd14);
    md_rsp_valid = 1'b1; md_rsp_dest = 5'd0; md_rsp_data = 32'h0000_1234;
    tick();
    md_rsp_valid = 1'b0;
    #1;
    check("t5_x0_load", {31'd0, rf_load}, 32'd0);
    check("t5_x0_busy", busy_vec, 32'h0000_4000);
    tick();
    check("t5_busy_keep", busy_vec, 32'h0000_4000);
    check("t5_popped", {31'd0, rf_load}, 32'd0);
    md_rsp_valid = 1'b1; md_rsp_dest = 5'd14; md_rsp_data = 32'h14;
    tick();
    md_rsp_valid = 1'b0;
    tick();
    check("t5_clean", busy_vec, 32'd0);

    // Reset with two buffered entries and x7/x8 outstanding.
    issue(5'd7); issue(5'd8);
    check("t6_busy", busy_vec, 32'h0000_0180);
    pipe_wb_valid = 1'b1;
    md_rsp_valid = 1'b1; md_rsp_dest = 5'd7; md_rsp_data = 32'h7;
    tick();
    md_rsp_dest = 5'd8; md_rsp_data = 32'h8;
    tick();
    md_rsp_valid = 1'b0;
    #1;
    check("t6_full", {31'd0, md_rsp_ready}, 32'd0);
    rst_n = 1'b0;
    dec_src_a = 5'd7;
    tick();
    check("t6_rst_busy", busy_vec, 32'd0);
    check("t6_rst_ready", {31'd0, md_rsp_ready}, 32'd0);
    check("t6_rst_load", {31'd0, rf_load}, 32'd0);
    check("t6_rst_stall", {31'd0, pipe_wb_stall}, 32'd0);
    check("t6_rst_haz", {31'd0, hazard_stall}, 32'd0);
    rst_n = 1'b1; pipe_wb_valid = 1'b0; dec_src_a = '0;
    #1;
    check("t6_rel_ready", {31'd0, md_rsp_ready}, 32'd1);
    check("t6_rel_load", {31'd0, rf_load}, 32'd0);
    tick();
    check("t6_empty", {31'd0, rf_load}, 32'd0);
    check("t6_rel_busy", busy_vec, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
